// File: rtl/host_bus_ctrl.sv
`timescale 1ns/1ps
// host_bus_ctrl: BBC Micro 1MHz-bus decoder (&FC40-&FC43) and SCSI ACK/SEL/RST sequencer.
// Every asynchronous input is double-synchronised; all outputs come straight from flops.
module host_bus_ctrl #(
    parameter int unsigned RST_CYCLES = 32,
    parameter int unsigned ACK_MIN    = 4
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       ONEMHZ,
    input  logic       nPGFC,
    input  logic       RnW,
    input  logic [1:0] A,
    input  logic       D_BIT0,
    input  logic       nREQ,
    input  logic       nBSY,
    input  logic       nMSG,
    input  logic       nCD,
    input  logic       nIO,
    output logic       DATA_LE,
    output logic       DATA_OE,
    output logic       STATUS_OE,
    output logic [7:0] STATUS,
    output logic       nACK,
    output logic       nSEL,
    output logic       nRST_SCSI,
    output logic       nIRQ
);

    typedef enum logic [1:0] {IDLE, ACK_HOLD, ACK_WAIT} ack_state_e;

    logic [6:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic       onemhz_s, npgfc_s, nreq_s, nbsy_s, nmsg_s, ncd_s, nio_s;
    logic       onemhz_prev_q, onemhz_prev_d;
    logic       cyc_valid_q, cyc_valid_d;
    logic [1:0] addr_q, addr_d;
    logic       rnw_q, rnw_d;
    logic       d0_q, d0_d;
    logic       data_le_q, data_le_d;
    logic       data_oe_q, data_oe_d;
    logic       status_oe_q, status_oe_d;
    ack_state_e state_q, state_d;
    logic [3:0] ack_cnt_q, ack_cnt_d;
    logic       nack_q, nack_d;
    logic       sel_q, sel_d;
    logic [7:0] rst_cnt_q, rst_cnt_d;
    logic       nrst_q, nrst_d;
    logic       irq_en_q, irq_en_d;
    logic       irq_q, irq_d;

    logic rise, fall, access_done, acc40, wr41, wr42, wr43, rst_active;

    assign {onemhz_s, npgfc_s, nreq_s, nbsy_s, nmsg_s, ncd_s, nio_s} = sync2_q;

    always_comb begin
        sync1_d       = {ONEMHZ, nPGFC, nREQ, nBSY, nMSG, nCD, nIO};
        sync2_d       = sync1_q;
        onemhz_prev_d = onemhz_s;

        rise = onemhz_s & ~onemhz_prev_q;
        fall = ~onemhz_s & onemhz_prev_q;

        cyc_valid_d = cyc_valid_q;
        addr_d      = addr_q;
        rnw_d       = rnw_q;
        d0_d        = d0_q;
        if (rise && !npgfc_s) begin
            cyc_valid_d = 1'b1;
            addr_d      = A;
            rnw_d       = RnW;
            d0_d        = D_BIT0;
        end else if (fall) begin
            cyc_valid_d = 1'b0;
        end

        // Address/direction stay latched after cyc_valid drops, so commands decode from them.
        access_done = fall & cyc_valid_q;
        acc40 = access_done && (addr_q == 2'd0);
        wr41  = access_done && (addr_q == 2'd1) && !rnw_q;
        wr42  = access_done && (addr_q == 2'd2) && !rnw_q;
        wr43  = access_done && (addr_q == 2'd3) && !rnw_q;

        data_le_d   = cyc_valid_d && (addr_d == 2'd0) && !rnw_d;
        data_oe_d   = cyc_valid_d && (addr_d == 2'd0) && rnw_d;
        status_oe_d = cyc_valid_d && (addr_d == 2'd1) && rnw_d;

        rst_cnt_d = rst_cnt_q;
        if (wr41) begin
            rst_cnt_d = 8'(RST_CYCLES);
        end else if (rst_cnt_q != '0) begin
            rst_cnt_d = rst_cnt_q - 8'd1;
        end
        rst_active = (rst_cnt_d != '0);
        nrst_d     = ~rst_active;

        state_d   = state_q;
        ack_cnt_d = ack_cnt_q;
        case (state_q)
            IDLE: begin
                if (acc40 && !nreq_s) begin
                    state_d   = ACK_HOLD;
                    ack_cnt_d = 4'(ACK_MIN - 1);
                end
            end
            ACK_HOLD: begin
                if (ack_cnt_q == '0) begin
                    state_d = ACK_WAIT;
                end else begin
                    ack_cnt_d = ack_cnt_q - 4'd1;
                end
            end
            ACK_WAIT: begin
                if (nreq_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Forcing on the next-cycle pulse state releases nACK on the same edge nRST_SCSI falls.
        if (rst_active) begin
            state_d = IDLE;
        end
        nack_d = (state_d == IDLE);

        sel_d = sel_q;
        if (wr42) begin
            sel_d = 1'b1;
        end
        if (!nbsy_s || rst_active) begin
            sel_d = 1'b0;
        end

        irq_en_d = irq_en_q;
        if (wr43) begin
            irq_en_d = d0_q;
        end
        irq_d = irq_en_q & ~nreq_s;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            onemhz_prev_q <= 1'b1;
            cyc_valid_q   <= 1'b0;
            addr_q        <= '0;
            rnw_q         <= 1'b1;
            d0_q          <= 1'b0;
            data_le_q     <= 1'b0;
            data_oe_q     <= 1'b0;
            status_oe_q   <= 1'b0;
            state_q       <= IDLE;
            ack_cnt_q     <= '0;
            nack_q        <= 1'b1;
            sel_q         <= 1'b0;
            rst_cnt_q     <= '0;
            nrst_q        <= 1'b1;
            irq_en_q      <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            onemhz_prev_q <= onemhz_prev_d;
            cyc_valid_q   <= cyc_valid_d;
            addr_q        <= addr_d;
            rnw_q         <= rnw_d;
            d0_q          <= d0_d;
            data_le_q     <= data_le_d;
            data_oe_q     <= data_oe_d;
            status_oe_q   <= status_oe_d;
            state_q       <= state_d;
            ack_cnt_q     <= ack_cnt_d;
            nack_q        <= nack_d;
            sel_q         <= sel_d;
            rst_cnt_q     <= rst_cnt_d;
            nrst_q        <= nrst_d;
            irq_en_q      <= irq_en_d;
            irq_q         <= irq_d;
        end
    end

    assign DATA_LE   = data_le_q;
    assign DATA_OE   = data_oe_q;
    assign STATUS_OE = status_oe_q;
    assign STATUS    = {~ncd_s, ~nio_s, ~nreq_s, irq_q, 2'b00, ~nbsy_s, ~nmsg_s};
    assign nACK      = nack_q;
    assign nSEL      = ~sel_q;
    assign nRST_SCSI = nrst_q;
    assign nIRQ      = ~irq_q;

endmodule

// File: tb/tb_host_bus_ctrl.sv
`timescale 1ns/1ps
// Bench for host_bus_ctrl: directed scenarios plus randomised host accesses scored against
// a cycle-count model of the bus protocol (strobe widths, ACK/RST pulse lengths, IRQ state).
module tb_host_bus_ctrl;

    localparam int unsigned RST_CYCLES = 32;
    localparam int unsigned ACK_MIN    = 4;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic       ONEMHZ = 1'b0;
    logic       nPGFC = 1'b1;
    logic       RnW = 1'b1;
    logic [1:0] A = 2'd0;
    logic       D_BIT0 = 1'b0;
    logic       nREQ = 1'b1, nBSY = 1'b1, nMSG = 1'b1, nCD = 1'b1, nIO = 1'b1;
    logic       DATA_LE, DATA_OE, STATUS_OE, nACK, nSEL, nRST_SCSI, nIRQ;
    logic [7:0] STATUS;

    host_bus_ctrl #(.RST_CYCLES(RST_CYCLES), .ACK_MIN(ACK_MIN)) dut (
        .CLK(CLK), .nRESET(nRESET), .ONEMHZ(ONEMHZ), .nPGFC(nPGFC), .RnW(RnW), .A(A),
        .D_BIT0(D_BIT0), .nREQ(nREQ), .nBSY(nBSY), .nMSG(nMSG), .nCD(nCD), .nIO(nIO),
        .DATA_LE(DATA_LE), .DATA_OE(DATA_OE), .STATUS_OE(STATUS_OE), .STATUS(STATUS),
        .nACK(nACK), .nSEL(nSEL), .nRST_SCSI(nRST_SCSI), .nIRQ(nIRQ)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    // Free-running per-cycle tallies of output activity, sampled on the falling clock edge.
    int cyc = 0, le_cnt = 0, oe_cnt = 0, soe_cnt = 0, ack_cnt = 0, rst_cnt = 0, sel_cnt = 0;
    int ack_run = 0, last_ack_run = 0;
    always @(negedge CLK) begin
        cyc++;
        if (DATA_LE === 1'b1) le_cnt++;
        if (DATA_OE === 1'b1) oe_cnt++;
        if (STATUS_OE === 1'b1) soe_cnt++;
        if (nRST_SCSI === 1'b0) rst_cnt++;
        if (nSEL === 1'b0) sel_cnt++;
        if (nACK === 1'b0) begin
            ack_cnt++;
            ack_run++;
        end else begin
            if (ack_run != 0) last_ack_run = ack_run;
            ack_run = 0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    // Returns 3 CLK after ONEMHZ falls: the first sample showing the effects of access_done.
    task automatic bus_cycle(input logic [1:0] addr, input logic rnw, input logic d0,
                             input logic pgfc_n, input int hi);
        A = addr; RnW = rnw; D_BIT0 = d0; nPGFC = pgfc_n;
        tick(2);
        ONEMHZ = 1'b1;
        tick(hi);
        ONEMHZ = 1'b0;
        tick(3);
        nPGFC = 1'b1; RnW = 1'b1;
    endtask

    task automatic test_reset();
        tick(3);
        total++; if ({DATA_LE, DATA_OE, STATUS_OE} !== 3'b000) begin bad++; $display("FAIL rst_oe_le: got %b want 000", {DATA_LE, DATA_OE, STATUS_OE}); end
        total++; if ({nACK, nSEL, nRST_SCSI, nIRQ} !== 4'b1111) begin bad++; $display("FAIL rst_nouts: got %b want 1111", {nACK, nSEL, nRST_SCSI, nIRQ}); end
        nRESET = 1'b1;
        tick(4);
        total++; if (STATUS !== 8'h00) begin bad++; $display("FAIL rst_status: got %h want 00", STATUS); end
        total++; if ({nACK, nSEL, nRST_SCSI, nIRQ, DATA_LE} !== 5'b11110) begin bad++; $display("FAIL rst_after_release: got %b want 11110", {nACK, nSEL, nRST_SCSI, nIRQ, DATA_LE}); end
    endtask

    task automatic test_write_ack();
        int l0, a0;
        nREQ = 1'b0;
        tick(4);
        l0 = le_cnt; a0 = ack_cnt;
        bus_cycle(2'd0, 1'b0, 1'b1, 1'b0, 16);
        total++; if (le_cnt - l0 !== 16) begin bad++; $display("FAIL w40_le_width: got %0d want 16", le_cnt - l0); end
        total++; if (DATA_LE !== 1'b0) begin bad++; $display("FAIL w40_le_fall: got %b want 0", DATA_LE); end
        total++; if (nACK !== 1'b0) begin bad++; $display("FAIL w40_nack_low: got %b want 0", nACK); end
        tick(10);
        nREQ = 1'b1;
        tick(2);
        total++; if (nACK !== 1'b0) begin bad++; $display("FAIL w40_nack_hold: got %b want 0", nACK); end
        tick(1);
        total++; if (nACK !== 1'b1) begin bad++; $display("FAIL w40_nack_release: got %b want 1", nACK); end
        total++; if (last_ack_run !== 13) begin bad++; $display("FAIL w40_ack_len: got %0d want 13", last_ack_run); end
        total++; if (ack_cnt - a0 !== 13) begin bad++; $display("FAIL w40_ack_total: got %0d want 13", ack_cnt - a0); end
    endtask

    task automatic test_read_noreq();
        int o0, a0, l0;
        o0 = oe_cnt; a0 = ack_cnt; l0 = le_cnt;
        bus_cycle(2'd0, 1'b1, 1'b0, 1'b0, 8);
        tick(6);
        total++; if (oe_cnt - o0 !== 8) begin bad++; $display("FAIL r40_oe_width: got %0d want 8", oe_cnt - o0); end
        total++; if (ack_cnt - a0 !== 0) begin bad++; $display("FAIL r40_no_ack: got %0d want 0", ack_cnt - a0); end
        total++; if (le_cnt - l0 !== 0) begin bad++; $display("FAIL r40_no_le: got %0d want 0", le_cnt - l0); end
    endtask

    task automatic test_sel();
        int s0;
        bus_cycle(2'd2, 1'b0, 1'b0, 1'b0, 8);
        total++; if (nSEL !== 1'b0) begin bad++; $display("FAIL sel_set: got %b want 0", nSEL); end
        tick(10);
        nBSY = 1'b0;
        tick(2);
        total++; if (nSEL !== 1'b0) begin bad++; $display("FAIL sel_hold: got %b want 0", nSEL); end
        tick(1);
        total++; if (nSEL !== 1'b1) begin bad++; $display("FAIL sel_clear: got %b want 1", nSEL); end
        s0 = sel_cnt;
        bus_cycle(2'd2, 1'b0, 1'b0, 1'b0, 8);
        tick(4);
        total++; if (sel_cnt - s0 !== 0) begin bad++; $display("FAIL sel_bsy_busy: got %0d low cycles want 0", sel_cnt - s0); end
        nBSY = 1'b1;
        tick(4);
    endtask

    task automatic test_irq();
        int q0;
        bus_cycle(2'd3, 1'b0, 1'b1, 1'b0, 8);
        nREQ = 1'b0;
        tick(4);
        total++; if (nIRQ !== 1'b0) begin bad++; $display("FAIL irq_assert: got %b want 0", nIRQ); end
        q0 = soe_cnt;
        bus_cycle(2'd1, 1'b1, 1'b0, 1'b0, 8);
        total++; if (soe_cnt - q0 !== 8) begin bad++; $display("FAIL irq_soe_width: got %0d want 8", soe_cnt - q0); end
        total++; if (STATUS !== 8'h30) begin bad++; $display("FAIL irq_status: got %h want 30", STATUS); end
        total++; if (nRST_SCSI !== 1'b1) begin bad++; $display("FAIL irq_read41_no_rst: got %b want 1", nRST_SCSI); end
        bus_cycle(2'd3, 1'b0, 1'b0, 1'b0, 8);
        tick(1);
        total++; if (nIRQ !== 1'b1) begin bad++; $display("FAIL irq_disable: got %b want 1", nIRQ); end
        nREQ = 1'b1;
        tick(4);
    endtask

    task automatic test_rst_during_ack();
        int r0, c1, c2;
        nREQ = 1'b0;
        tick(4);
        bus_cycle(2'd0, 1'b0, 1'b0, 1'b0, 8);
        tick(8);
        total++; if (nACK !== 1'b0) begin bad++; $display("FAIL rst_ackwait: got %b want 0", nACK); end
        r0 = rst_cnt;
        bus_cycle(2'd1, 1'b0, 1'b0, 1'b0, 8);
        c1 = cyc;
        total++; if ({nRST_SCSI, nACK} !== 2'b01) begin bad++; $display("FAIL rst_start_ack_release: got %b want 01", {nRST_SCSI, nACK}); end
        bus_cycle(2'd2, 1'b0, 1'b0, 1'b0, 6);
        total++; if (nSEL !== 1'b1) begin bad++; $display("FAIL rst_sel_blocked: got %b want 1", nSEL); end
        bus_cycle(2'd1, 1'b0, 1'b0, 1'b0, 4);
        c2 = cyc;
        bus_cycle(2'd0, 1'b1, 1'b0, 1'b0, 4);
        total++; if (nACK !== 1'b1) begin bad++; $display("FAIL rst_ack_blocked: got %b want 1", nACK); end
        tick(RST_CYCLES + 5);
        total++; if (rst_cnt - r0 !== (c2 - c1) + RST_CYCLES) begin bad++; $display("FAIL rst_len_reload: got %0d want %0d", rst_cnt - r0, (c2 - c1) + RST_CYCLES); end
        total++; if ({nRST_SCSI, nSEL, nACK} !== 3'b111) begin bad++; $display("FAIL rst_end_state: got %b want 111", {nRST_SCSI, nSEL, nACK}); end
        nREQ = 1'b1;
        tick(4);
    endtask

    task automatic test_random();
        logic       m_irq_en = 1'b0;
        logic [1:0] addr;
        logic       rnw, d0, pgfc_n, req, cd, io, msg, hit, exp_ack, exp_rst, exp_sel, exp_irq;
        logic [7:0] exp_status;
        int hi, d, l0, o0, q0, a0, r0, exp_len;
        for (int it = 0; it < 30; it++) begin
            addr = 2'($urandom_range(0, 3)); rnw = 1'($urandom_range(0, 1)); d0 = 1'($urandom_range(0, 1));
            pgfc_n = ($urandom_range(0, 4) == 0); req = 1'($urandom_range(0, 1));
            cd = 1'($urandom_range(0, 1)); io = 1'($urandom_range(0, 1)); msg = 1'($urandom_range(0, 1));
            hi = int'($urandom_range(3, 12)); d = int'($urandom_range(0, 10));
            nCD = ~cd; nIO = ~io; nMSG = ~msg; nREQ = ~req;
            tick(4);
            l0 = le_cnt; o0 = oe_cnt; q0 = soe_cnt; a0 = ack_cnt; r0 = rst_cnt;
            bus_cycle(addr, rnw, d0, pgfc_n, hi);
            hit     = !pgfc_n;
            exp_ack = hit && addr == 2'd0 && req;
            exp_rst = hit && addr == 2'd1 && !rnw;
            exp_sel = hit && addr == 2'd2 && !rnw;
            if (hit && addr == 2'd3 && !rnw) m_irq_en = d0;
            exp_irq = m_irq_en && req;
            exp_len = exp_ack ? ((d + 4 > int'(ACK_MIN) + 1) ? d + 4 : int'(ACK_MIN) + 1) : 0;
            total++; if (le_cnt - l0 !== ((hit && addr == 2'd0 && !rnw) ? hi : 0)) begin bad++; $display("FAIL rnd%0d_le: got %0d cycles", it, le_cnt - l0); end
            total++; if (oe_cnt - o0 !== ((hit && addr == 2'd0 && rnw) ? hi : 0)) begin bad++; $display("FAIL rnd%0d_oe: got %0d cycles", it, oe_cnt - o0); end
            total++; if (soe_cnt - q0 !== ((hit && addr == 2'd1 && rnw) ? hi : 0)) begin bad++; $display("FAIL rnd%0d_soe: got %0d cycles", it, soe_cnt - q0); end
            total++; if ({nACK, nRST_SCSI, nSEL} !== {~exp_ack, ~exp_rst, ~exp_sel}) begin bad++; $display("FAIL rnd%0d_cmd: got %b want %b", it, {nACK, nRST_SCSI, nSEL}, {~exp_ack, ~exp_rst, ~exp_sel}); end
            tick(1);
            exp_status = {cd, io, req, exp_irq, 2'b00, 1'b0, msg};
            total++; if (nIRQ !== ~exp_irq) begin bad++; $display("FAIL rnd%0d_irq: got %b want %b", it, nIRQ, ~exp_irq); end
            total++; if (STATUS !== exp_status) begin bad++; $display("FAIL rnd%0d_status: got %h want %h", it, STATUS, exp_status); end
            tick(d);
            nREQ = 1'b1;
            tick(RST_CYCLES + 6);
            total++; if (ack_cnt - a0 !== exp_len) begin bad++; $display("FAIL rnd%0d_ack_len: got %0d want %0d", it, ack_cnt - a0, exp_len); end
            total++; if (rst_cnt - r0 !== (exp_rst ? int'(RST_CYCLES) : 0)) begin bad++; $display("FAIL rnd%0d_rst_len: got %0d", it, rst_cnt - r0); end
            if (exp_sel) begin
                nBSY = 1'b0;
                tick(3);
                total++; if (nSEL !== 1'b1) begin bad++; $display("FAIL rnd%0d_sel_clear: got %b want 1", it, nSEL); end
                nBSY = 1'b1;
                tick(2);
            end
        end
        nCD = 1'b1; nIO = 1'b1; nMSG = 1'b1;
        if (m_irq_en) bus_cycle(2'd3, 1'b0, 1'b0, 1'b0, 4);
        tick(4);
    endtask

    task automatic test_async_reset();
        bus_cycle(2'd3, 1'b0, 1'b1, 1'b0, 6);
        nREQ = 1'b0;
        tick(4);
        total++; if (nIRQ !== 1'b0) begin bad++; $display("FAIL ares_irq_pre: got %b want 0", nIRQ); end
        A = 2'd0; RnW = 1'b0; nPGFC = 1'b0;
        tick(2);
        ONEMHZ = 1'b1;
        tick(5);
        total++; if (DATA_LE !== 1'b1) begin bad++; $display("FAIL ares_le_pre: got %b want 1", DATA_LE); end
        #2 nRESET = 1'b0;
        #1;
        total++; if ({DATA_LE, DATA_OE, STATUS_OE, nACK, nSEL, nRST_SCSI, nIRQ} !== 7'b0001111) begin bad++; $display("FAIL ares_outputs: got %b want 0001111", {DATA_LE, DATA_OE, STATUS_OE, nACK, nSEL, nRST_SCSI, nIRQ}); end
        total++; if (STATUS !== 8'h00) begin bad++; $display("FAIL ares_status: got %h want 00", STATUS); end
        tick(2);
        nRESET = 1'b1;
        ONEMHZ = 1'b0;
        tick(6);
        nPGFC = 1'b1; RnW = 1'b1;
        total++; if ({nIRQ, nACK, DATA_LE} !== 3'b110) begin bad++; $display("FAIL ares_after: got %b want 110", {nIRQ, nACK, DATA_LE}); end
        nREQ = 1'b1;
        tick(4);
    endtask

    initial begin
        test_reset();
        test_write_ack();
        test_read_noreq();
        test_sel();
        test_irq();
        test_rst_during_ack();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
